// File: rtl/dft_pkg.sv
// Shared types and twiddle table for the radix-2 DFT stage.
// Sine quarter-wave for N up to 64, scaled by 2^16.
package dft_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int TAB_Q = 16;

  function automatic int ew(input int n);
    return $clog2(n);
  endfunction

  function automatic int tw_one(input int tw_w);
    return 1 << (tw_w - 2);
  endfunction

  // sin(pi*x/32) * 2^16, x = 0..16
  function automatic int sin_q(input int x);
    int v;
    case (x)
      0:       v = 0;
      1:       v = 6424;
      2:       v = 12785;
      3:       v = 19024;
      4:       v = 25080;
      5:       v = 30893;
      6:       v = 36410;
      7:       v = 41576;
      8:       v = 46341;
      9:       v = 50660;
      10:      v = 54491;
      11:      v = 57798;
      12:      v = 60547;
      13:      v = 62714;
      14:      v = 64277;
      15:      v = 65220;
      default: v = 65536;
    endcase
    return v;
  endfunction

  // Rescale a non-negative magnitude to 2^(tw_w-2), rounding half up
  function automatic int tw_scale(input int mag, input int tw_w);
    int sh;
    sh = TAB_Q - (tw_w - 2);
    if (sh > 0) return (mag + (1 << (sh - 1))) >>> sh;
    return mag << (-sh);
  endfunction

endpackage

// File: rtl/dft_tw_rom.sv
// Combinational twiddle lookup: exponent e -> W_N^e.
// Quadrant folding onto the shared quarter-wave table.
module dft_tw_rom
  import dft_pkg::*;
#(
  parameter int TW_W = 10,
  parameter int N    = 16,
  localparam int EW  = ew(N)
) (
  input  logic [EW-1:0]          e,
  output logic signed [TW_W-1:0] re,
  output logic signed [TW_W-1:0] im
);

  localparam int SH = 6 - EW;

  logic [5:0] k;
  logic [1:0] q;
  logic [3:0] r;
  int mre;
  int mim;

  assign k = 6'(e) << SH;
  assign q = k[5:4];
  assign r = k[3:0];

  always_comb begin
    mre = tw_scale(sin_q(q[0] ? int'(r) : 16 - int'(r)), TW_W);
    mim = tw_scale(sin_q(q[0] ? 16 - int'(r) : int'(r)), TW_W);
    re  = (q == 2'd1 || q == 2'd2) ? TW_W'(-mre) : TW_W'(mre);
    im  = q[1] ? TW_W'(mim) : TW_W'(-mim);
  end

endmodule

// File: rtl/dft_tw_sequencer.sv
// Frame sequencer presenting one twiddle set per butterfly group.
// Sets stream on valid/ready; frames chain back-to-back.
module dft_tw_sequencer
  import dft_pkg::*;
#(
  parameter int TW_W = 10,
  parameter int N    = 16,
  parameter int NGRP = 4,
  parameter int STEP = 1,
  localparam int EW  = ew(N),
  localparam int GW  = (NGRP > 1) ? $clog2(NGRP) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [TW_W-1:0] w0_r,
  output logic signed [TW_W-1:0] w0_i,
  output logic signed [TW_W-1:0] w4_r,
  output logic signed [TW_W-1:0] w4_i,
  output logic signed [TW_W-1:0] w8_r,
  output logic signed [TW_W-1:0] w8_i,
  output logic signed [TW_W-1:0] w12_r,
  output logic signed [TW_W-1:0] w12_i,
  output logic [GW-1:0]          grp_idx,
  output logic                   m_last,
  output logic                   busy
);

  localparam logic [GW-1:0] GLAST = GW'(NGRP - 1);

  state_t state, nstate;
  logic accept, adv, load, fin;
  logic [GW-1:0] gnext;
  logic [EW-1:0] acc  [4];
  logic [EW-1:0] nacc [4];
  logic signed [TW_W-1:0] rre [4];
  logic signed [TW_W-1:0] rim [4];
  logic signed [TW_W-1:0] wre [4];
  logic signed [TW_W-1:0] wim [4];

  assign accept = s_valid & s_ready;
  assign adv    = (state == RUN) & m_ready & ~m_last & ~flush;
  assign fin    = (state == RUN) & m_ready & m_last;
  assign load   = accept | adv;
  assign gnext  = grp_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (flush) begin
      nstate = IDLE;
    end else begin
      unique case (state)
        IDLE: if (s_valid) nstate = RUN;
        RUN:  if (fin && !s_valid) nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready = 1'b0;
    unique case (state)
      IDLE: s_ready = ~flush;
      RUN:  s_ready = ~flush & m_last & m_ready;
    endcase
  end

  assign busy    = (state == RUN);
  assign m_valid = (state == RUN);

  // Accumulators track the exponent of the set currently presented
  for (genvar j = 0; j < 4; j++) begin : g_slot
    localparam logic [EW-1:0] INC = EW'((j * STEP) % N);
    assign nacc[j] = accept ? '0 : acc[j] + INC;
    dft_tw_rom #(
      .TW_W(TW_W),
      .N   (N)
    ) u_rom (
      .e (nacc[j]),
      .re(rre[j]),
      .im(rim[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_idx <= '0;
      m_last  <= 1'b0;
      for (int j = 0; j < 4; j++) begin
        acc[j] <= '0;
        wre[j] <= '0;
        wim[j] <= '0;
      end
    end else if (flush) begin
      grp_idx <= '0;
      m_last  <= 1'b0;
      for (int j = 0; j < 4; j++) begin
        acc[j] <= '0;
        wre[j] <= '0;
        wim[j] <= '0;
      end
    end else if (load) begin
      grp_idx <= accept ? '0 : gnext;
      m_last  <= accept ? (NGRP == 1) : (gnext == GLAST);
      for (int j = 0; j < 4; j++) begin
        acc[j] <= nacc[j];
        wre[j] <= rre[j];
        wim[j] <= rim[j];
      end
    end else if (fin) begin
      m_last <= 1'b0;
    end
  end

  assign w0_r  = wre[0];
  assign w0_i  = wim[0];
  assign w4_r  = wre[1];
  assign w4_i  = wim[1];
  assign w8_r  = wre[2];
  assign w8_i  = wim[2];
  assign w12_r = wre[3];
  assign w12_i = wim[3];

endmodule

// File: tb/tb_dft_tw_sequencer.sv
// Scoreboard bench for dft_tw_sequencer (default and NGRP=8/STEP=2).
// Expected sets come from a cos/sin model with half-away rounding.
module tb_dft_tw_sequencer;

  logic clk;
  logic rst_n;
  logic flush;
  logic s_valid;
  logic s_ready;
  logic m_valid;
  logic m_ready;
  logic signed [9:0] w_r [4];
  logic signed [9:0] w_i [4];
  logic [1:0] grp_idx;
  logic m_last;
  logic busy;

  logic b_s_valid;
  logic b_s_ready;
  logic b_m_valid;
  logic b_m_ready;
  logic signed [9:0] bw_r [4];
  logic signed [9:0] bw_i [4];
  logic [2:0] b_grp;
  logic b_m_last;
  logic b_busy;

  int total = 0;
  int bad   = 0;
  int nsets = 0;
  int q[$];

  dft_tw_sequencer u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .w0_r   (w_r[0]),
    .w0_i   (w_i[0]),
    .w4_r   (w_r[1]),
    .w4_i   (w_i[1]),
    .w8_r   (w_r[2]),
    .w8_i   (w_i[2]),
    .w12_r  (w_r[3]),
    .w12_i  (w_i[3]),
    .grp_idx(grp_idx),
    .m_last (m_last),
    .busy   (busy)
  );

  dft_tw_sequencer #(
    .TW_W(10),
    .N   (16),
    .NGRP(8),
    .STEP(2)
  ) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (1'b0),
    .s_valid(b_s_valid),
    .s_ready(b_s_ready),
    .m_valid(b_m_valid),
    .m_ready(b_m_ready),
    .w0_r   (bw_r[0]),
    .w0_i   (bw_i[0]),
    .w4_r   (bw_r[1]),
    .w4_i   (bw_i[1]),
    .w8_r   (bw_r[2]),
    .w8_i   (bw_i[2]),
    .w12_r  (bw_r[3]),
    .w12_i  (bw_i[3]),
    .grp_idx(b_grp),
    .m_last (b_m_last),
    .busy   (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int tw_re(input int e, input int n);
    real a;
    a = 2.0 * 3.14159265358979 * e / n;
    return rnd($cos(a) * 256.0);
  endfunction

  function automatic int tw_im(input int e, input int n);
    real a;
    a = 2.0 * 3.14159265358979 * e / n;
    return rnd(-$sin(a) * 256.0);
  endfunction

  // Each set is 10 entries: grp, last, then (re, im) per slot
  task automatic push_frame(input int ngrp, input int step, input int n);
    for (int g = 0; g < ngrp; g++) begin
      q.push_back(g);
      q.push_back(g == ngrp - 1 ? 1 : 0);
      for (int j = 0; j < 4; j++) begin
        q.push_back(tw_re((j * g * step) % n, n));
        q.push_back(tw_im((j * g * step) % n, n));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (q.size() < 10) begin
        chk("spurious_set", 1, 0);
      end else begin
        int act [10];
        act[0] = int'(grp_idx);
        act[1] = int'(m_last);
        for (int j = 0; j < 4; j++) begin
          act[2 + 2 * j] = int'(w_r[j]);
          act[3 + 2 * j] = int'(w_i[j]);
        end
        for (int k = 0; k < 10; k++)
          chk($sformatf("set_f%0d", k), act[k], q[k]);
        if (m_ready) begin
          for (int k = 0; k < 10; k++) void'(q.pop_front());
          nsets++;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    b_s_valid = 1'b0;
    b_m_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_mvalid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grp", int'(grp_idx), 0);
    chk("rst_last", int'(m_last), 0);
    for (int j = 0; j < 4; j++) begin
      chk("rst_wr", int'(w_r[j]), 0);
      chk("rst_wi", int'(w_i[j]), 0);
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_sready", int'(s_ready), 1);
    chk("idle_mvalid", int'(m_valid), 0);

    // single frame, no backpressure
    cyc();
    s_valid = 1'b1;
    m_ready = 1'b1;
    push_frame(4, 1, 16);
    @(negedge clk);
    chk("t2_accept", int'(s_ready), 1);
    cyc();
    s_valid = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("t2_end_mvalid", int'(m_valid), 0);
    chk("t2_q_empty", q.size(), 0);

    // backpressure at g=2
    cyc();
    s_valid = 1'b1;
    push_frame(4, 1, 16);
    cyc();
    s_valid = 1'b0;
    cyc();
    cyc();
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_grp", int'(grp_idx), 2);
      chk("t3_hold_sready", int'(s_ready), 0);
      cyc();
    end
    m_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("t3_grp3", int'(grp_idx), 3);
    chk("t3_last", int'(m_last), 1);
    repeat (2) cyc();
    @(negedge clk);
    chk("t3_end_mvalid", int'(m_valid), 0);
    chk("t3_q_empty", q.size(), 0);

    // back-to-back frames
    cyc();
    s_valid = 1'b1;
    push_frame(4, 1, 16);
    push_frame(4, 1, 16);
    @(negedge clk);
    chk("t4_sready_idle", int'(s_ready), 1);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 8) s_valid = 1'b0;
      @(negedge clk);
      chk("t4_sready", int'(s_ready), (i == 4 || i == 8) ? 1 : 0);
      chk("t4_mvalid", int'(m_valid), 1);
    end
    cyc();
    @(negedge clk);
    chk("t4_end_mvalid", int'(m_valid), 0);
    chk("t4_q_empty", q.size(), 0);

    // flush at g=1 with a frame offered
    cyc();
    s_valid = 1'b1;
    push_frame(4, 1, 16);
    cyc();
    cyc();
    flush = 1'b1;
    @(negedge clk);
    chk("t5_sready_flush", int'(s_ready), 0);
    cyc();
    flush = 1'b0;
    s_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("t5_mvalid", int'(m_valid), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_grp", int'(grp_idx), 0);
    chk("t5_w4r", int'(w_r[1]), 0);
    chk("t5_sready", int'(s_ready), 1);
    cyc();
    s_valid = 1'b1;
    push_frame(4, 1, 16);
    cyc();
    s_valid = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("t5_end_mvalid", int'(m_valid), 0);
    chk("t5_q_empty", q.size(), 0);

    // async reset mid-frame
    cyc();
    s_valid = 1'b1;
    push_frame(4, 1, 16);
    cyc();
    s_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("ar_mvalid", int'(m_valid), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_grp", int'(grp_idx), 0);
    chk("ar_w4r", int'(w_r[1]), 0);
    chk("ar_w4i", int'(w_i[1]), 0);
    q.delete();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_sready", int'(s_ready), 1);
    chk("ar_idle_mvalid", int'(m_valid), 0);

    // NGRP=8, STEP=2: wrap mod N at g=4
    cyc();
    b_s_valid = 1'b1;
    b_m_ready = 1'b1;
    cyc();
    b_s_valid = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("t6_grp", int'(b_grp), 4);
    chk("t6_last", int'(b_m_last), 0);
    for (int j = 0; j < 4; j++) begin
      chk("t6_wr", int'(bw_r[j]), tw_re((j * 8) % 16, 16));
      chk("t6_wi", int'(bw_i[j]), tw_im((j * 8) % 16, 16));
    end
    chk("t6_w4r_neg", int'(bw_r[1]), -256);
    chk("t6_w8r_pos", int'(bw_r[2]), 256);
    repeat (3) cyc();
    @(negedge clk);
    chk("t6_grp7", int'(b_grp), 7);
    chk("t6_last7", int'(b_m_last), 1);
    repeat (2) cyc();
    @(negedge clk);
    chk("t6_end_mvalid", int'(b_m_valid), 0);

    chk("set_count", nsets, 23);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
